hier_node_responder: RTL and testbench
======================================

// Module: hier_node_responder
// PURPOSE
//  Response-side endpoint for one node of the generated module hierarchy. The parent node issues a
//  request downward; this node broadcasts it to NUM_CHILDREN child instances and collects one
//  response from each. It then returns a single aggregated response (error OR, responder count,
//  timeout flag) to the parent. Nodes chain recursively: each node's dn_* ports drive the children's up_*.
// PARAMETERS
//  NUM_CHILDREN  5     number of child instances fanned out to (1..32)
//  ID_W          8     request tag width, echoed unchanged in the response
//  TIMEOUT_CYC   1024  max cycles in WAIT before forced response (>=2)
// PORTS
//  clk            in   1              rising-edge clock
//  rst_n          in   1              asynchronous active-low reset
//  up_req_valid   in   1              parent request valid
//  up_req_ready   out  1              node can accept request (high only in IDLE)
//  up_req_id      in   ID_W           request tag
//  up_rsp_valid   out  1              aggregated response valid
//  up_rsp_ready   in   1              parent accepts response
//  up_rsp_id      out  ID_W           echoed tag
//  up_rsp_err     out  1              OR of err from all accepted child responses
//  up_rsp_cnt     out  $clog2(N+1)    number of children that responded
//  up_rsp_timeout out  1              response forced by timeout
//  dn_req_valid   out  NUM_CHILDREN   per-child request valid
//  dn_req_ready   in   NUM_CHILDREN   per-child request ready
//  dn_req_id      out  ID_W           tag broadcast to all children
//  dn_rsp_valid   in   NUM_CHILDREN   per-child response strobe (single cycle, no backpressure)
//  dn_rsp_err     in   NUM_CHILDREN   per-child error, qualified by dn_rsp_valid
//  busy           out  1              state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync-released by top): state=IDLE.
//    All outputs 0 except up_req_ready=1. Internal id/err/cnt/masks/timer = 0.
//  - All outputs are registered or decoded from registered state only; no in->out combinational path.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE:
//    - on up_req_valid&up_req_ready: capture id; req_mask=all 1s; pend=0; err=0; cnt=0; timer=0.
//    - -> WAIT.
//  - WAIT:
//    - dn_req_valid=req_mask. Bit i clears and pend[i] sets on dn_req_valid[i]&dn_req_ready[i].
//    - Response from child i is accepted if pend[i] is set, or its request handshakes in the same cycle.
//    - Accept = clear pend[i], cnt+=1, err|=dn_rsp_err[i].
//    - dn_rsp_valid for a child with no outstanding request is ignored: no count, no error.
//    - Multiple children may respond in one cycle: cnt adds popcount.
//    - Leave when req_mask==0 and pend==0 (after the update) -> RESP, timeout=0.
//    - timer increments each WAIT cycle. When timer==TIMEOUT_CYC-1 and not done -> RESP, timeout=1.
//      On timeout, drop all dn_req_valid and discard pend.
//    - Completion wins over timeout in the same cycle.
//  - RESP:
//    - up_rsp_valid=1; id/err/cnt/timeout stable until up_rsp_ready.
//    - On handshake -> IDLE; up_req_ready=1 the next cycle.
//    - Late child responses in RESP/IDLE are ignored.
//  - Latency: best case is accept at cycle 0, dn_req_valid at cycle 1,
//    all children ready+respond at cycle 1, up_rsp_valid at cycle 2.
//  - up_req_valid outside IDLE is not accepted (ready=0); the request stays pending upstream.
//  - rst_n asserted mid-transaction: immediate return to reset values; the transaction is lost, no response.
// STRUCTURE
//  - Package hier_node_pkg:
//    - node_state_e {IDLE, WAIT, RESP}
//    - default localparams for ID_W and TIMEOUT_CYC
//    - function popcount for the cnt update
//  - One sub-module: hier_timeout_ctr (clear, enable, terminal-count output). All else inline.
// TESTING
//  - Reset: rst_n=0 -> up_req_ready=1, up_rsp_valid=0, dn_req_valid=5'b0, busy=0.
//  - Happy path, N=5: id=8'hA5, all dn_req_ready=1, each child responds err=0 one cycle later.
//    -> up_rsp id=A5, cnt=5, err=0, timeout=0.
//  - Staggered ready (child3 ready 10 cycles late) with child1 err=1.
//    -> dn_req_valid[3] held 10 cycles; rsp cnt=5, err=1.
//  - Child4 never responds, TIMEOUT_CYC=16.
//    -> up_rsp_valid 16 cycles after WAIT entry; cnt=4, timeout=1; dn_req_valid=0.
//  - up_rsp_ready held low 7 cycles -> up_rsp fields stable; a second up_req_valid is not accepted until after handshake.
//  - Spurious dn_rsp_valid[2] in IDLE, plus rst_n pulse mid-WAIT.
//    -> no count change; after reset all outputs at reset values; a new request completes normally.

Source files
------------

// File: rtl/hier_node_pkg.sv
// Shared types, default parameters and helpers for the hierarchy response node.
package hier_node_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } node_state_e;

  localparam int DEF_NUM_CHILDREN = 5;
  localparam int DEF_ID_W         = 8;
  localparam int DEF_TIMEOUT_CYC  = 1024;
  localparam int MAX_CHILDREN     = 32;

  // Number of set bits in a (zero-extended) child mask.
  function automatic logic [5:0] popcount(input logic [MAX_CHILDREN-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAX_CHILDREN; i++) begin
      c = c + {5'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/hier_timeout_ctr.sv
// Free-running wait timer: cleared while idle, counts while enabled,
// flags the final cycle of the allowed window.
module hier_timeout_ctr #(
  parameter int MAX_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(MAX_CYC - 1));

endmodule

// File: rtl/hier_node_responder.sv
// One node of the request hierarchy: fans a parent request out to all
// children, collects one response per child and returns an aggregate.
module hier_node_responder
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = DEF_NUM_CHILDREN,
  parameter int ID_W         = DEF_ID_W,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              up_req_valid,
  output logic                              up_req_ready,
  input  logic [ID_W-1:0]                   up_req_id,
  output logic                              up_rsp_valid,
  input  logic                              up_rsp_ready,
  output logic [ID_W-1:0]                   up_rsp_id,
  output logic                              up_rsp_err,
  output logic [$clog2(NUM_CHILDREN+1)-1:0] up_rsp_cnt,
  output logic                              up_rsp_timeout,
  output logic [NUM_CHILDREN-1:0]           dn_req_valid,
  input  logic [NUM_CHILDREN-1:0]           dn_req_ready,
  output logic [ID_W-1:0]                   dn_req_id,
  input  logic [NUM_CHILDREN-1:0]           dn_rsp_valid,
  input  logic [NUM_CHILDREN-1:0]           dn_rsp_err,
  output logic                              busy
);

  // Handshake rule on every port pair: a transfer happens on the rising
  // edge where valid and ready are both high; valid never depends on ready.
  // Child responses are single-cycle strobes without backpressure.

  localparam int CNT_W = $clog2(NUM_CHILDREN + 1);

  node_state_e state_q, state_d;

  logic [ID_W-1:0]         id_q, id_d;
  logic [NUM_CHILDREN-1:0] req_mask_q, req_mask_d;
  logic [NUM_CHILDREN-1:0] pend_q, pend_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;

  logic [NUM_CHILDREN-1:0] req_hs, acc, mask_upd, pend_upd;
  logic [MAX_CHILDREN-1:0] acc_ext;
  logic [5:0]              acc_pop;
  logic                    done, tc;

  hier_timeout_ctr #(
    .MAX_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q == IDLE),
    .en_i  (state_q == WAIT),
    .tc_o  (tc)
  );

  // Per-cycle child bookkeeping: a response counts only if its request is
  // already pending or handshakes in this same cycle.
  always_comb begin
    req_hs   = req_mask_q & dn_req_ready;
    acc      = dn_rsp_valid & (pend_q | req_hs);
    acc_ext  = '0;
    acc_ext[NUM_CHILDREN-1:0] = acc;
    acc_pop  = popcount(acc_ext);
    mask_upd = req_mask_q & ~req_hs;
    pend_upd = (pend_q | req_hs) & ~acc;
    done     = (mask_upd == '0) && (pend_upd == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; completion takes precedence over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (up_req_valid)  state_d = WAIT;
      WAIT:    if (done || tc)    state_d = RESP;
      RESP:    if (up_rsp_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    up_req_ready = (state_q == IDLE);
    up_rsp_valid = (state_q == RESP);
    busy         = (state_q != IDLE);
    dn_req_valid = (state_q == WAIT) ? req_mask_q : '0;
  end

  // Datapath next values: capture on accept, accumulate in WAIT, hold in RESP.
  always_comb begin
    id_d       = id_q;
    req_mask_d = req_mask_q;
    pend_d     = pend_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (up_req_valid) begin
          id_d       = up_req_id;
          req_mask_d = '1;
          pend_d     = '0;
          err_d      = 1'b0;
          cnt_d      = '0;
          timeout_d  = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = CNT_W'(int'(cnt_q) + int'(acc_pop));
        err_d = err_q | (|(acc & dn_rsp_err));
        if (done) begin
          req_mask_d = mask_upd;
          pend_d     = pend_upd;
          timeout_d  = 1'b0;
        end else if (tc) begin
          // Give up on stragglers: withdraw requests and forget pending ones.
          req_mask_d = '0;
          pend_d     = '0;
          timeout_d  = 1'b1;
        end else begin
          req_mask_d = mask_upd;
          pend_d     = pend_upd;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      req_mask_q <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      id_q       <= id_d;
      req_mask_q <= req_mask_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign up_rsp_id      = id_q;
  assign up_rsp_err     = err_q;
  assign up_rsp_cnt     = cnt_q;
  assign up_rsp_timeout = timeout_q;
  assign dn_req_id      = id_q;

endmodule

// File: tb/tb_hier_node_responder.sv
// Bench for hier_node_responder: child models, directed scenarios and a
// response scoreboard fed at request time and drained by a monitor.
module tb_hier_node_responder;

  localparam int N   = 5;
  localparam int IDW = 8;
  localparam int TO  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           up_req_valid, up_req_ready;
  logic [IDW-1:0] up_req_id;
  logic           up_rsp_valid, up_rsp_ready;
  logic [IDW-1:0] up_rsp_id;
  logic           up_rsp_err;
  logic [2:0]     up_rsp_cnt;
  logic           up_rsp_timeout;
  logic [N-1:0]   dn_req_valid, dn_req_ready;
  logic [IDW-1:0] dn_req_id;
  logic [N-1:0]   dn_rsp_valid, dn_rsp_err;
  logic           busy;

  hier_node_responder #(
    .NUM_CHILDREN (N),
    .ID_W         (IDW),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .up_req_valid   (up_req_valid),
    .up_req_ready   (up_req_ready),
    .up_req_id      (up_req_id),
    .up_rsp_valid   (up_rsp_valid),
    .up_rsp_ready   (up_rsp_ready),
    .up_rsp_id      (up_rsp_id),
    .up_rsp_err     (up_rsp_err),
    .up_rsp_cnt     (up_rsp_cnt),
    .up_rsp_timeout (up_rsp_timeout),
    .dn_req_valid   (dn_req_valid),
    .dn_req_ready   (dn_req_ready),
    .dn_req_id      (dn_req_id),
    .dn_rsp_valid   (dn_rsp_valid),
    .dn_rsp_err     (dn_rsp_err),
    .busy           (busy)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [12:0] exp_q[$];  // {id, err, cnt, timeout}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- child models ----------------
  logic [N-1:0] rsp_v, rsp_e, spur_v, spur_e, rsp_due, err_cfg, mute;
  int ready_delay[N];
  int wait_cnt[N];
  int stall3;

  assign dn_rsp_valid = rsp_v | spur_v;
  assign dn_rsp_err   = rsp_e | spur_e;

  // Each child raises ready after ready_delay cycles of seeing its request,
  // then answers with a one-cycle strobe in the following cycle.
  initial begin
    rsp_v = '0; rsp_e = '0; rsp_due = '0; dn_req_ready = '0; stall3 = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      rsp_v = '0;
      rsp_e = '0;
      for (int i = 0; i < N; i++) begin
        if (rsp_due[i]) begin
          rsp_v[i]   = !mute[i];
          rsp_e[i]   = err_cfg[i] & !mute[i];
          rsp_due[i] = 1'b0;
        end
        if (dn_req_valid[i]) begin
          if (wait_cnt[i] >= ready_delay[i]) begin
            dn_req_ready[i] = 1'b1;
            rsp_due[i]      = 1'b1;
            wait_cnt[i]     = 0;
          end else begin
            dn_req_ready[i] = 1'b0;
            wait_cnt[i]++;
            if (i == 3) stall3++;
          end
        end else begin
          dn_req_ready[i] = 1'b0;
          wait_cnt[i]     = 0;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (rst_n && up_rsp_valid && up_rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {up_rsp_id, up_rsp_err, up_rsp_cnt, up_rsp_timeout}, 32'hFFFF_FFFF);
      end else begin
        chk("rsp_fields", {up_rsp_id, up_rsp_err, up_rsp_cnt, up_rsp_timeout}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] id, input logic err, input logic [2:0] cnt,
                          input logic to, input bit push);
    logic rdy;
    bit   got;
    got = 1'b0;
    up_req_id    = id;
    up_req_valid = 1'b1;
    if (push) exp_q.push_back({id, err, cnt, to});
    for (int k = 0; k < 50; k++) begin
      rdy = up_req_ready;
      tick();
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    up_req_valid = 1'b0;
    if (!got) chk("req_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!up_rsp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    if (!up_rsp_valid) chk("rsp_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 50; k++) begin
      if (!up_rsp_valid) break;
      tick();
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    rst_n = 1'b0; up_req_valid = 1'b0; up_req_id = '0; up_rsp_ready = 1'b1;
    spur_v = '0; spur_e = '0; err_cfg = '0; mute = '0;
    for (int i = 0; i < N; i++) ready_delay[i] = 0;
    repeat (3) tick();
    chk("rst_req_ready", up_req_ready, 1);
    chk("rst_rsp_valid", up_rsp_valid, 0);
    chk("rst_dn_valid",  dn_req_valid, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_cnt",       up_rsp_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Happy path: all ready at once, all answer one cycle later.
    send_req(8'hA5, 1'b0, 3'd5, 1'b0, 1'b1);
    chk("happy_dn_valid", dn_req_valid, 5'h1F);
    chk("happy_dn_id",    dn_req_id, 8'hA5);
    chk("happy_busy",     busy, 1);
    wait_rsp(cyc);
    chk("happy_latency",  cyc, 2);
    wait_done();

    // Child 3 ready 10 cycles late, child 1 reports error, stray strobe on child 3.
    ready_delay[3] = 10;
    err_cfg = 5'b00010;
    stall3 = 0;
    send_req(8'hC3, 1'b1, 3'd5, 1'b0, 1'b1);
    tick();
    tick();
    spur_v = 5'b01000; spur_e = 5'b01000;
    tick();
    spur_v = '0; spur_e = '0;
    wait_rsp(cyc);
    chk("stagger_held", stall3, 10);
    wait_done();
    ready_delay[3] = 0;
    err_cfg = '0;

    // Child 4 never answers: forced response after the timeout window.
    mute = 5'b10000;
    send_req(8'h5E, 1'b0, 3'd4, 1'b1, 1'b1);
    wait_rsp(cyc);
    chk("to_latency",  cyc, TO);
    chk("to_dn_valid", dn_req_valid, 0);
    wait_done();
    mute = '0;

    // Parent stalls the response for 7 cycles while a second request waits.
    up_rsp_ready = 1'b0;
    send_req(8'h3C, 1'b0, 3'd5, 1'b0, 1'b1);
    wait_rsp(cyc);
    up_req_id    = 8'h77;
    up_req_valid = 1'b1;
    exp_q.push_back({8'h77, 1'b0, 3'd5, 1'b0});
    for (int k = 0; k < 7; k++) begin
      chk("hold_fields", {up_rsp_valid, up_rsp_id, up_rsp_err, up_rsp_cnt, up_rsp_timeout},
          {1'b1, 8'h3C, 1'b0, 3'd5, 1'b0});
      chk("hold_no_accept", up_req_ready, 0);
      tick();
    end
    up_rsp_ready = 1'b1;
    tick();
    chk("hold_ready_after", up_req_ready, 1);
    tick();
    chk("second_busy", busy, 1);
    up_req_valid = 1'b0;
    wait_rsp(cyc);
    wait_done();

    // Stray child strobe while idle.
    spur_v = 5'b00100; spur_e = 5'b00100;
    tick();
    spur_v = '0; spur_e = '0;
    tick();
    chk("idle_spur_busy",  busy, 0);
    chk("idle_spur_valid", up_rsp_valid, 0);

    // Reset in the middle of WAIT: transaction dropped, no response.
    for (int i = 0; i < N; i++) ready_delay[i] = 8;
    send_req(8'h11, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("midwait_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", up_req_ready, 1);
    chk("midrst_rsp_valid", up_rsp_valid, 0);
    chk("midrst_dn_valid",  dn_req_valid, 0);
    chk("midrst_busy",      busy, 0);
    chk("midrst_cnt",       up_rsp_cnt, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) ready_delay[i] = 0;
    tick();

    // Fresh request after reset completes normally.
    send_req(8'h5A, 1'b0, 3'd5, 1'b0, 1'b1);
    wait_rsp(cyc);
    chk("post_rst_latency", cyc, 2);
    wait_done();

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
